// File: rtl/mem_bank_arb.sv
// mem_bank_arb: word-interleaved banked memory shared by an IF read port and a DM read/write port,
//   with per-bank round-robin arbitration, req/gnt handshakes and WAIT_CYC busy cycles per access.
//   Optional feature macro: MEM_BANK_ARB_CONFLICT_CNT_EN adds the saturating conflict_cnt output.
module mem_bank_arb #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 14,
   parameter int NUM_BANKS = 2,
   parameter int WAIT_CYC  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [DATA_W/8-1:0] dm_web,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   output logic                dm_gnt,
   output logic                dm_rvalid,
`ifdef MEM_BANK_ARB_CONFLICT_CNT_EN
   output logic [31:0]         conflict_cnt,
`endif
   output logic [DATA_W-1:0]   dm_rdata
);
   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NUM_BANKS);
   localparam int BW = (LB > 0) ? LB : 1;
   localparam int OW = ADDR_W - LB;
   localparam int CW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

   typedef enum logic {FREE, BUSY} bank_st_e;

   logic [DATA_W-1:0]    mem [NUM_BANKS][2**OW];
   bank_st_e             st_q [NUM_BANKS];
   bank_st_e             st_d [NUM_BANKS];
   logic [CW-1:0]        cnt_q [NUM_BANKS];
   logic [CW-1:0]        cnt_d [NUM_BANKS];
   logic [NUM_BANKS-1:0] rr_q, rr_d;
   logic [BW-1:0]        if_bk, dm_bk;
   logic [OW-1:0]        if_off, dm_off;
   logic                 if_free, dm_free, coll;
   logic [1:0]           rd_gnt;
   logic [DATA_W-1:0]    rd_mem [2];
   logic [WAIT_CYC:0]    v_q [2];
   logic [WAIT_CYC:0]    v_d [2];
   logic [DATA_W-1:0]    d_q [2][WAIT_CYC+1];
   logic [DATA_W-1:0]    d_d [2][WAIT_CYC+1];

   // decode bank/offset and grant: free bank only, rr_q bit set means IF wins the next collision
   always_comb begin
      if_bk     = (LB > 0) ? BW'(if_addr) : '0;
      dm_bk     = (LB > 0) ? BW'(dm_addr) : '0;
      if_off    = OW'(if_addr >> LB);
      dm_off    = OW'(dm_addr >> LB);
      if_free   = st_q[if_bk] == FREE;
      dm_free   = st_q[dm_bk] == FREE;
      coll      = !rst && if_req && dm_req && if_bk == dm_bk && if_free;
      if_gnt    = !rst && if_req && if_free && !(coll && !rr_q[if_bk]);
      dm_gnt    = !rst && dm_req && dm_free && !(coll && rr_q[dm_bk]);
      rd_gnt    = {dm_gnt && !dm_we, if_gnt};
      rd_mem[0] = mem[if_bk][if_off];
      rd_mem[1] = mem[dm_bk][dm_off];
   end

   // bank FSM next state: a grant holds the bank BUSY for WAIT_CYC cycles; pointer flips only on collisions
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         st_d[b]  = st_q[b];
         cnt_d[b] = cnt_q[b];
         if ((if_gnt && if_bk == BW'(b)) || (dm_gnt && dm_bk == BW'(b))) begin
            st_d[b]  = (WAIT_CYC > 0) ? BUSY : FREE;
            cnt_d[b] = CW'(WAIT_CYC);
         end else if (st_q[b] == BUSY) begin
            st_d[b]  = (cnt_q[b] == CW'(1)) ? FREE : BUSY;
            cnt_d[b] = cnt_q[b] - CW'(1);
         end
         rr_d[b] = (coll && if_bk == BW'(b)) ? !rr_q[b] : rr_q[b];
      end
   end

   // read return pipeline: valid shifts each cycle, data advances only behind a valid so rdata holds
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         v_d[p]    = v_q[p];
         v_d[p][0] = rd_gnt[p];
         d_d[p][0] = rd_gnt[p] ? rd_mem[p] : d_q[p][0];
         for (int i = 1; i <= WAIT_CYC; i++) begin
            v_d[p][i] = v_q[p][i-1];
            d_d[p][i] = v_q[p][i-1] ? d_q[p][i-1] : d_q[p][i];
         end
      end
   end

   // state and pipeline registers; reset cancels busy banks and in-flight responses
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            st_q[b]  <= FREE;
            cnt_q[b] <= '0;
         end
         rr_q <= '0;
         for (int p = 0; p < 2; p++) begin
            v_q[p] <= '0;
            for (int i = 0; i <= WAIT_CYC; i++) d_q[p][i] <= '0;
         end
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         rr_q  <= rr_d;
         v_q   <= v_d;
         d_q   <= d_d;
      end
   end

   // byte-masked DM write commits at the grant edge; contents survive reset
   always_ff @(posedge clk) begin
      if (dm_gnt && dm_we)
         for (int i = 0; i < NB; i++)
            if (!dm_web[i]) mem[dm_bk][dm_off][i*8 +: 8] <= dm_wdata[i*8 +: 8];
   end

   assign if_rvalid = v_q[0][WAIT_CYC];
   assign if_rdata  = d_q[0][WAIT_CYC];
   assign dm_rvalid = v_q[1][WAIT_CYC];
   assign dm_rdata  = d_q[1][WAIT_CYC];

`ifdef MEM_BANK_ARB_CONFLICT_CNT_EN
   logic [31:0] conflict_cnt_q, conflict_cnt_d, deny;

   // add the number of denied requests this cycle, saturating at all-ones
   always_comb begin
      deny           = 32'(if_req && !if_gnt) + 32'(dm_req && !dm_gnt);
      conflict_cnt_d = (conflict_cnt_q > 32'hFFFF_FFFF - deny) ? 32'hFFFF_FFFF : conflict_cnt_q + deny;
   end

   // conflict counter register
   always_ff @(posedge clk) begin
      if (rst) conflict_cnt_q <= '0;
      else     conflict_cnt_q <= conflict_cnt_d;
   end

   assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_mem_bank_arb.sv
// tb_mem_bank_arb: two configurations (2 banks/0 waits, 4 banks/2 waits) driven by directed then random
//   requesters and checked each cycle against a cycle-count based reference model.
module tb_mem_bank_arb;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  web;
      logic [3:0]  addr;
      logic [31:0] wd;
   } stim_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       if_req, dm_req, dm_we;
   logic [1:0][3:0]  if_addr, dm_addr, dm_web;
   logic [1:0][31:0] dm_wdata;
   wire  [1:0]       if_gnt, if_rvalid, dm_gnt, dm_rvalid;
   wire  [1:0][31:0] if_rdata, dm_rdata;
`ifdef MEM_BANK_ARB_CONFLICT_CNT_EN
   wire  [1:0][31:0] cc;
`endif

   int          n_cmp = 0, n_err = 0, cyc = 0;
   stim_t       sq [4][$];
   stim_t       cur [4];
   logic        hold [4];
   logic [31:0] mm [2][16];
   int          free_at [2][4];
   logic        fav_if [2][4];
   logic        ev [4][8];
   logic [31:0] ed [4][8];
   logic [31:0] last [4];
   logic [31:0] cm [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_bank_arb #(.DATA_W(32), .ADDR_W(4), .NUM_BANKS(g ? 4 : 2), .WAIT_CYC(g ? 2 : 0)) u_dut (
         .clk(clk), .rst(rst),
         .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
         .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
         .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_web(dm_web[g]), .dm_addr(dm_addr[g]),
         .dm_wdata(dm_wdata[g]), .dm_gnt(dm_gnt[g]), .dm_rvalid(dm_rvalid[g]),
`ifdef MEM_BANK_ARB_CONFLICT_CNT_EN
         .conflict_cnt(cc[g]),
`endif
         .dm_rdata(dm_rdata[g]));
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic void push(int p, logic rq, logic we, logic [3:0] web, logic [3:0] a, logic [31:0] wd);
      stim_t s;
      s = '{req: rq, we: we, web: web, addr: a, wd: wd};
      sq[p].push_back(s);
      sq[p+2].push_back(s);
   endfunction

   function automatic stim_t rnd(int p);
      stim_t s;
      s.req  = $urandom_range(0, 3) != 0;
      s.we   = p == 1 && $urandom_range(0, 1) == 1;
      s.web  = s.we ? 4'($urandom) : 4'hF;
      s.addr = 4'($urandom);
      s.wd   = $urandom;
      return s;
   endfunction

   task automatic drive();
      for (int k = 0; k < 2; k++) begin
         if_req[k]   = cur[2*k].req;
         if_addr[k]  = cur[2*k].addr;
         dm_req[k]   = cur[2*k+1].req;
         dm_we[k]    = cur[2*k+1].we;
         dm_web[k]   = cur[2*k+1].web;
         dm_addr[k]  = cur[2*k+1].addr;
         dm_wdata[k] = cur[2*k+1].wd;
      end
   endtask

   task automatic model_reset(int k);
      for (int b = 0; b < 4; b++) begin
         free_at[k][b] = 0;
         fav_if[k][b]  = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
         last[2*k+p] = '0;
         for (int s = 0; s < 8; s++) ev[2*k+p][s] = 1'b0;
      end
      cm[k] = '0;
   endtask

   // one cycle of the reference: predict grants, check outputs, then advance the model
   task automatic step(int k);
      int    w, nb, ib, db, j, s, due;
      stim_t si, sd;
      logic  gi, gd;
      w  = k ? 2 : 0;
      nb = k ? 4 : 2;
      si = cur[2*k];
      sd = cur[2*k+1];
      ib = int'(si.addr) % nb;
      db = int'(sd.addr) % nb;
      s  = cyc % 8;
      due = (cyc + w + 1) % 8;
      gi = !rst && si.req && cyc >= free_at[k][ib];
      gd = !rst && sd.req && cyc >= free_at[k][db];
      if (gi && gd && ib == db) begin
         if (fav_if[k][ib]) gd = 1'b0;
         else gi = 1'b0;
         fav_if[k][ib] = gd;
      end
      check($sformatf("k%0d if_gnt", k), 32'(if_gnt[k]), 32'(gi));
      check($sformatf("k%0d dm_gnt", k), 32'(dm_gnt[k]), 32'(gd));
`ifdef MEM_BANK_ARB_CONFLICT_CNT_EN
      check($sformatf("k%0d conflict_cnt", k), cc[k], cm[k]);
`endif
      for (int p = 0; p < 2; p++) begin
         j = 2*k + p;
         check($sformatf("k%0d p%0d rvalid", k, p), 32'(p ? dm_rvalid[k] : if_rvalid[k]), 32'(ev[j][s]));
         if (ev[j][s]) last[j] = ed[j][s];
         ev[j][s] = 1'b0;
         check($sformatf("k%0d p%0d rdata", k, p), p ? dm_rdata[k] : if_rdata[k], last[j]);
      end
      if (rst) model_reset(k);
      else begin
         cm[k] += 32'(si.req && !gi) + 32'(sd.req && !gd);
         if (gi) begin
            free_at[k][ib] = cyc + w + 1;
            ev[2*k][due]   = 1'b1;
            ed[2*k][due]   = mm[k][si.addr];
         end
         if (gd) begin
            free_at[k][db] = cyc + w + 1;
            if (sd.we) begin
               for (int i = 0; i < 4; i++)
                  if (!sd.web[i]) mm[k][sd.addr][i*8 +: 8] = sd.wd[i*8 +: 8];
            end else begin
               ev[2*k+1][due] = 1'b1;
               ed[2*k+1][due] = mm[k][sd.addr];
            end
         end
      end
      hold[2*k]   = si.req && !gi;
      hold[2*k+1] = sd.req && !gd;
   endtask

   initial begin
      for (int j = 0; j < 4; j++) begin
         cur[j]  = '{req: 1'b1, we: 1'b0, web: 4'hF, addr: 4'h0, wd: 32'h0};
         hold[j] = 1'b0;
      end
      rst = 1'b1;
      drive();
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("k%0d rst if_gnt", k), 32'(if_gnt[k]), 32'h0);
         check($sformatf("k%0d rst dm_gnt", k), 32'(dm_gnt[k]), 32'h0);
         check($sformatf("k%0d rst if_rvalid", k), 32'(if_rvalid[k]), 32'h0);
         check($sformatf("k%0d rst dm_rvalid", k), 32'(dm_rvalid[k]), 32'h0);
         check($sformatf("k%0d rst if_rdata", k), if_rdata[k], 32'h0);
         check($sformatf("k%0d rst dm_rdata", k), dm_rdata[k], 32'h0);
         model_reset(k);
      end
      for (int j = 0; j < 4; j++) cur[j].req = 1'b0;
      drive();
      @(posedge clk);
      #1;
      for (int a = 0; a < 16; a++) begin
         push(1, 1'b1, 1'b1, 4'h0, 4'(a), $urandom);
         push(0, 1'b0, 1'b0, 4'hF, 4'h0, 32'h0);
      end
      push(1, 1'b1, 1'b1, 4'h0, 4'h4, 32'hDEAD_BEEF);  push(0, 1'b0, 1'b0, 4'hF, 4'h0, 32'h0);
      push(1, 1'b0, 1'b0, 4'hF, 4'h0, 32'h0);          push(0, 1'b1, 1'b0, 4'hF, 4'h4, 32'h0);
      push(1, 1'b1, 1'b1, 4'hE, 4'h4, 32'h0000_0011);  push(0, 1'b0, 1'b0, 4'hF, 4'h0, 32'h0);
      push(1, 1'b1, 1'b0, 4'hF, 4'h4, 32'h0);          push(0, 1'b0, 1'b0, 4'hF, 4'h0, 32'h0);
      push(1, 1'b1, 1'b0, 4'hF, 4'h6, 32'h0);          push(0, 1'b1, 1'b0, 4'hF, 4'h2, 32'h0);
      push(1, 1'b0, 1'b0, 4'hF, 4'h0, 32'h0);          push(0, 1'b1, 1'b0, 4'hF, 4'h2, 32'h0);
      push(1, 1'b1, 1'b0, 4'hF, 4'h6, 32'h0);          push(0, 1'b1, 1'b0, 4'hF, 4'h1, 32'h0);
      push(1, 1'b1, 1'b0, 4'hF, 4'h2, 32'h0);
      for (cyc = 0; cyc < 4000; cyc++) begin
         rst = cyc > 200 && $urandom_range(0, 149) == 0;
         for (int j = 0; j < 4; j++)
            if (!hold[j]) begin
               if (sq[j].size() > 0) cur[j] = sq[j].pop_front();
               else cur[j] = rnd(j % 2);
            end
         drive();
         @(negedge clk);
         step(0);
         step(1);
         @(posedge clk);
         #1;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
